int_sequencer: RTL and testbench

//  Generates the INT pseudo-instruction sequence that the control unit decodes.

---
 rtl/int_sequencer_pkg.sv | 37 +++
 rtl/int_sequencer_edge_latch.sv | 31 +++
 rtl/int_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_int_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the INT pseudo-instruction sequencer and the RTI pop logic.
// The push order below is the stack layout that RTI must unwind in reverse.
package int_sequencer_pkg;

  localparam int DATA_W       = 16;
  localparam int PC_W         = 2 * DATA_W;
  localparam int FLAG_W       = 4;
  localparam int DRAIN_CYCLES = 3;
  localparam int VEC_ADDR     = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARMED,
    S_DRAIN,
    S_PUSH_HI,
    S_PUSH_LO,
    S_PUSH_FL,
    S_VEC_HI,
    S_VEC_LO,
    S_LOAD
  } int_state_e;

  typedef enum logic [1:0] {
    PC_HI = 2'd0,
    PC_LO = 2'd1,
    FLAGS = 2'd2
  } push_slot_e;

  function automatic push_slot_e push_slot(input int_state_e s);
    case (s)
      S_PUSH_LO: return PC_LO;
      S_PUSH_FL: return FLAGS;
      default:   return PC_HI;
    endcase
  endfunction

endpackage

// File: rtl/int_sequencer_edge_latch.sv
// Rising-edge detector for the interrupt request plus a one-deep pending bit.
// Further edges merge into the pending bit; a new edge wins over a same-cycle clear.
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic int_req_i,
  input  logic clear_i,
  output logic pending_o
);

  logic req_q, req_d;
  logic pending_q, pending_d;

  always_comb begin
    req_d     = int_req_i;
    pending_d = (int_req_i && !req_q) || (pending_q && !clear_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/int_sequencer.sv
// INT sequencer: waits for a safe boundary, drains, pushes PC/flags, fetches the vector, loads PC.
// Optional INT_MASK_EN adds int_mask_i, which blocks entry while high (pending still latches).
module int_sequencer #(
  parameter int DATA_W       = int_sequencer_pkg::DATA_W,
  parameter int PC_W         = 2 * DATA_W,
  parameter int FLAG_W       = int_sequencer_pkg::FLAG_W,
  parameter int DRAIN_CYCLES = int_sequencer_pkg::DRAIN_CYCLES,
  parameter int VEC_ADDR     = int_sequencer_pkg::VEC_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req_i,
  input  logic              stall_i,
  input  logic              jmp_pending_i,
  input  logic [PC_W-1:0]   pc_decode_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic              rti_i,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef INT_MASK_EN
  input  logic              int_mask_i,
`endif
  output logic              int_o,
  output logic              flush_o,
  output logic              stall_fetch_o,
  output logic              stack_push_o,
  output logic [DATA_W-1:0] stack_wdata_o,
  output logic              vec_rd_o,
  output logic [DATA_W-1:0] vec_addr_o,
  output logic              pc_load_o,
  output logic [PC_W-1:0]   pc_load_val_o,
  output logic              in_service_o
);

  import int_sequencer_pkg::*;

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  int_state_e        state_q, state_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [DATA_W-1:0] vec_hi_q, vec_hi_d;
  logic [DATA_W-1:0] vec_lo_q, vec_lo_d;
  logic              in_service_q, in_service_d;
  logic              pending, pending_clr, masked, entry_ok;

  int_edge_latch u_edge_latch (
    .clk       (clk),
    .rst       (rst),
    .int_req_i (int_req_i),
    .clear_i   (pending_clr),
    .pending_o (pending)
  );

`ifdef INT_MASK_EN
  assign masked = int_mask_i;
`else
  assign masked = 1'b0;
`endif

  // An RTI retiring this cycle frees the handler slot in time for a held request.
  assign entry_ok = pending && !masked && (!in_service_q || rti_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drain_cnt_q  <= '0;
      pc_q         <= '0;
      flags_q      <= '0;
      vec_hi_q     <= '0;
      vec_lo_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      pc_q         <= pc_d;
      flags_q      <= flags_d;
      vec_hi_q     <= vec_hi_d;
      vec_lo_q     <= vec_lo_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    pc_d         = pc_q;
    flags_d      = flags_q;
    vec_hi_d     = vec_hi_q;
    vec_lo_d     = vec_lo_q;
    pending_clr  = 1'b0;
    in_service_d = in_service_q;
    if (state_q == S_LOAD)
      in_service_d = 1'b1;
    else if (rti_i)
      in_service_d = 1'b0;
    case (state_q)
      S_IDLE: if (entry_ok) state_d = S_ARMED;
      S_ARMED: begin
        // The resume point is the instruction in decode at the moment the boundary is safe.
        if (!stall_i && !jmp_pending_i) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
          pc_d        = pc_decode_i;
          flags_d     = flags_i;
          pending_clr = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1))
          state_d = S_PUSH_HI;
        else
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
      end
      S_PUSH_HI: if (mem_ready_i) state_d = S_PUSH_LO;
      S_PUSH_LO: if (mem_ready_i) state_d = S_PUSH_FL;
      S_PUSH_FL: if (mem_ready_i) state_d = S_VEC_HI;
      S_VEC_HI: begin
        if (mem_ready_i) begin
          vec_hi_d = mem_rdata_i;
          state_d  = S_VEC_LO;
        end
      end
      S_VEC_LO: begin
        if (mem_ready_i) begin
          vec_lo_d = mem_rdata_i;
          state_d  = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_o         = 1'b0;
    flush_o       = 1'b0;
    stall_fetch_o = 1'b0;
    stack_push_o  = 1'b0;
    stack_wdata_o = '0;
    vec_rd_o      = 1'b0;
    vec_addr_o    = '0;
    pc_load_o     = 1'b0;
    pc_load_val_o = '0;
    case (state_q)
      S_DRAIN: begin
        int_o         = 1'b1;
        stall_fetch_o = 1'b1;
        flush_o       = 1'b1;
      end
      S_PUSH_HI, S_PUSH_LO, S_PUSH_FL: begin
        int_o         = 1'b1;
        stall_fetch_o = 1'b1;
        stack_push_o  = 1'b1;
        case (push_slot(state_q))
          PC_HI:   stack_wdata_o = pc_q[PC_W-1:DATA_W];
          PC_LO:   stack_wdata_o = pc_q[DATA_W-1:0];
          default: stack_wdata_o = DATA_W'(flags_q);
        endcase
      end
      S_VEC_HI, S_VEC_LO: begin
        int_o         = 1'b1;
        stall_fetch_o = 1'b1;
        vec_rd_o      = 1'b1;
        vec_addr_o    = (state_q == S_VEC_HI) ? DATA_W'(VEC_ADDR) : DATA_W'(VEC_ADDR + 1);
      end
      S_LOAD: begin
        int_o         = 1'b1;
        stall_fetch_o = 1'b1;
        pc_load_o     = 1'b1;
        pc_load_val_o = {vec_hi_q, vec_lo_q};
      end
      default: ;
    endcase
  end

  assign in_service_o = in_service_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: a vector table for the basic sequence plus hand-written
// corner-case sequences (branch/stall hold-off, memory back-pressure, reset, RTI re-entry, mask).
`timescale 1ns/1ps
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req, stall, jmp, rti, mem_ready;
  logic [31:0] pc_decode;
  logic [3:0]  flags;
  logic [15:0] mem_rdata;
`ifdef INT_MASK_EN
  logic        int_mask;
`endif
  logic        int_o, flush_o, stall_fetch_o, stack_push_o, vec_rd_o, pc_load_o, in_service_o;
  logic [15:0] stack_wdata_o, vec_addr_o;
  logic [31:0] pc_load_val_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .int_req_i     (int_req),
    .stall_i       (stall),
    .jmp_pending_i (jmp),
    .pc_decode_i   (pc_decode),
    .flags_i       (flags),
    .rti_i         (rti),
    .mem_ready_i   (mem_ready),
    .mem_rdata_i   (mem_rdata),
`ifdef INT_MASK_EN
    .int_mask_i    (int_mask),
`endif
    .int_o         (int_o),
    .flush_o       (flush_o),
    .stall_fetch_o (stall_fetch_o),
    .stack_push_o  (stack_push_o),
    .stack_wdata_o (stack_wdata_o),
    .vec_rd_o      (vec_rd_o),
    .vec_addr_o    (vec_addr_o),
    .pc_load_o     (pc_load_o),
    .pc_load_val_o (pc_load_val_o),
    .in_service_o  (in_service_o)
  );

  typedef struct packed {
    logic        int_o;
    logic        flush;
    logic        stall_fetch;
    logic        push;
    logic [15:0] wdata;
    logic        vec_rd;
    logic [15:0] vec_addr;
    logic        pc_load;
    logic [31:0] pc_val;
    logic        in_service;
  } outs_t;

  typedef struct {
    logic        int_req, stall, jmp, rti, mem_ready;
    logic [15:0] rdata;
    outs_t       exp;
  } vec_t;

  outs_t act;
  assign act = {int_o, flush_o, stall_fetch_o, stack_push_o, stack_wdata_o,
                vec_rd_o, vec_addr_o, pc_load_o, pc_load_val_o, in_service_o};

  function automatic outs_t o_idle(input logic svc);
    outs_t o = '0;
    o.in_service = svc;
    return o;
  endfunction

  function automatic outs_t o_drain();
    outs_t o = '0;
    o.int_o = 1'b1; o.flush = 1'b1; o.stall_fetch = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_push(input logic [15:0] w);
    outs_t o = '0;
    o.int_o = 1'b1; o.stall_fetch = 1'b1; o.push = 1'b1; o.wdata = w;
    return o;
  endfunction

  function automatic outs_t o_vec(input logic [15:0] a);
    outs_t o = '0;
    o.int_o = 1'b1; o.stall_fetch = 1'b1; o.vec_rd = 1'b1; o.vec_addr = a;
    return o;
  endfunction

  function automatic outs_t o_load(input logic [31:0] v);
    outs_t o = '0;
    o.int_o = 1'b1; o.stall_fetch = 1'b1; o.pc_load = 1'b1; o.pc_val = v;
    return o;
  endfunction

  function automatic vec_t mk(input logic req, st, jp, rt, mr, input logic [15:0] rd,
                              input outs_t e);
    vec_t v;
    v.int_req = req; v.stall = st; v.jmp = jp; v.rti = rt; v.mem_ready = mr;
    v.rdata = rd; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, st, jp, rt, mr, input logic [15:0] rd);
    int_req   = req;
    stall     = st;
    jmp       = jp;
    rti       = rt;
    mem_ready = mr;
    mem_rdata = rd;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got int=%b fl=%b sf=%b push=%b wd=%h rd=%b ad=%h ld=%b val=%h svc=%b, expected int=%b fl=%b sf=%b push=%b wd=%h rd=%b ad=%h ld=%b val=%h svc=%b",
               name, act.int_o, act.flush, act.stall_fetch, act.push, act.wdata, act.vec_rd,
               act.vec_addr, act.pc_load, act.pc_val, act.in_service,
               exp.int_o, exp.flush, exp.stall_fetch, exp.push, exp.wdata, exp.vec_rd,
               exp.vec_addr, exp.pc_load, exp.pc_val, exp.in_service);
    end
  endtask

  task automatic step(input string name, input logic req, st, jp, rt, mr,
                      input logic [15:0] rd, input outs_t exp);
    applyStimulus(req, st, jp, rt, mr, rd);
    checkOutput(name, exp);
    tick();
  endtask

  vec_t tbl [13];

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end of the test");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Basic sequence, one row per cycle, memory always ready.
    tbl[0]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_idle(1'b0));
    tbl[1]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_idle(1'b0));
    tbl[2]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_idle(1'b0));
    tbl[3]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_drain());
    tbl[4]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_drain());
    tbl[5]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_drain());
    tbl[6]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_push(16'h0001));
    tbl[7]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_push(16'h2340));
    tbl[8]  = mk(1, 0, 0, 0, 1, 16'hDEAD, o_push(16'h000A));
    tbl[9]  = mk(1, 0, 0, 0, 1, 16'h0000, o_vec(16'h0000));
    tbl[10] = mk(1, 0, 0, 0, 1, 16'h0100, o_vec(16'h0001));
    tbl[11] = mk(1, 0, 0, 0, 1, 16'hDEAD, o_load(32'h0000_0100));
    tbl[12] = mk(1, 0, 0, 0, 1, 16'hDEAD, o_idle(1'b1));

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    pc_decode = 32'h0001_2340;
    flags     = 4'b1010;
`ifdef INT_MASK_EN
    int_mask  = 1'b0;
`endif
    tick();
    checkOutput("reset", o_idle(1'b0));
    tick();
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      step($sformatf("basic[%0d]", i), tbl[i].int_req, tbl[i].stall, tbl[i].jmp,
           tbl[i].rti, tbl[i].mem_ready, tbl[i].rdata, tbl[i].exp);

    // RTI, then an entry held off by an unresolved branch and a stall.
    pc_decode = 32'hABCD_5678;
    flags     = 4'b0011;
    step("rti_prep", 0, 0, 0, 0, 0, 16'h0, o_idle(1'b1));
    step("rti",      0, 0, 0, 1, 0, 16'h0, o_idle(1'b1));
    step("jmp_edge", 1, 0, 1, 0, 0, 16'h0, o_idle(1'b0));
    step("jmp_idle", 1, 0, 1, 0, 0, 16'h0, o_idle(1'b0));
    for (int i = 0; i < 5; i++)
      step($sformatf("jmp_armed[%0d]", i), 1, 0, 1, 0, 0, 16'h0, o_idle(1'b0));
    step("stall_armed", 1, 1, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("jmp_release", 1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    for (int i = 0; i < 3; i++)
      step($sformatf("jmp_drain[%0d]", i), 1, 0, 0, 0, 0, 16'h0, o_drain());

    // Memory back-pressure in PUSH_LO; a new edge arrives while busy.
    step("push_hi",       1, 0, 0, 0, 1, 16'h0, o_push(16'hABCD));
    step("push_lo_wait0", 0, 0, 0, 0, 0, 16'h0, o_push(16'h5678));
    step("push_lo_wait1", 1, 0, 0, 0, 0, 16'h0, o_push(16'h5678));
    step("push_lo_go",    1, 0, 0, 0, 1, 16'h0, o_push(16'h5678));

    // Reset in PUSH_FL must abort and drop the pending request.
    rst = 1'b1;
    step("push_fl_rst", 0, 0, 0, 0, 0, 16'h0, o_push(16'h0003));
    rst = 1'b0;
    step("after_rst",    0, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("rst_no_pend0", 0, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("rst_no_pend1", 0, 0, 0, 0, 0, 16'h0, o_idle(1'b0));

    // Second edge during service waits for RTI, then arms the next cycle.
    pc_decode = 32'h0BAD_F00D;
    flags     = 4'b1111;
    step("svc_edge",    1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("svc_idle",    1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("svc_armed",   1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("svc_drain0",  1, 0, 0, 0, 0, 16'h0, o_drain());
    step("svc_drain1",  0, 0, 0, 0, 0, 16'h0, o_drain());
    step("svc_drain2",  1, 0, 0, 0, 0, 16'h0, o_drain());
    step("svc_push_hi", 1, 0, 0, 0, 1, 16'h0, o_push(16'h0BAD));
    step("svc_push_lo", 1, 0, 0, 0, 1, 16'h0, o_push(16'hF00D));
    step("svc_push_fl", 1, 0, 0, 0, 1, 16'h0, o_push(16'h000F));
    step("svc_vec_hi",  1, 0, 0, 0, 1, 16'h1234, o_vec(16'h0000));
    step("svc_vec_lo",  1, 0, 0, 0, 1, 16'h5678, o_vec(16'h0001));
    step("svc_load",    1, 0, 0, 0, 0, 16'h0, o_load(32'h1234_5678));
    for (int i = 0; i < 3; i++)
      step($sformatf("svc_wait[%0d]", i), 1, 0, 0, 0, 0, 16'h0, o_idle(1'b1));
    step("svc_rti",     1, 0, 0, 1, 0, 16'h0, o_idle(1'b1));
    step("rti_armed",   1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("rti_drain",   1, 0, 0, 0, 0, 16'h0, o_drain());

`ifdef INT_MASK_EN
    // Masked request latches but cannot arm until the mask drops.
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 16'h0);
    tick();
    rst = 1'b0;
    int_mask = 1'b1;
    step("mask_edge", 1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    for (int i = 0; i < 3; i++)
      step($sformatf("mask_hold[%0d]", i), 1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    int_mask = 1'b0;
    step("mask_drop",  1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("mask_armed", 1, 0, 0, 0, 0, 16'h0, o_idle(1'b0));
    step("mask_drain", 1, 0, 0, 0, 0, 16'h0, o_drain());
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
